// File: rtl/soma_pkg.sv
// Shared definitions for the soma sweep engine: model encodings, FSM states and
// the signed saturation helper used by the Vm update path.
package soma_pkg;

  localparam logic [1:0] ModeLif     = 2'b00;
  localparam logic [1:0] ModeIf      = 2'b01;
  localparam logic [1:0] ModePoisson = 2'b10;
  localparam logic [1:0] ModeOff     = 2'b11;

  typedef enum logic [2:0] {StIdle, StRd, StEv, StSpk, StDone} soma_state_e;

  // Widest Vm supported by saturate(); callers sign-extend into SatXW bits.
  localparam int unsigned SatMaxW = 32;
  localparam int unsigned SatXW   = SatMaxW + 2;

  // Clamp x to the signed range of a w-bit value (w <= SatMaxW).
  function automatic logic [SatMaxW-1:0] saturate(input logic signed [SatXW-1:0] x,
                                                  input int unsigned w);
    logic signed [SatXW-1:0] hi;
    logic signed [SatXW-1:0] lo;
    logic [5:0]              msb;
    msb     = 6'(w - 1);
    hi      = '0;
    hi[msb] = 1'b1;
    hi      = hi - SatXW'(1);
    lo      = -hi - SatXW'(1);
    if (x > hi) begin
      return hi[SatMaxW-1:0];
    end else if (x < lo) begin
      return lo[SatMaxW-1:0];
    end
    return x[SatMaxW-1:0];
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one combinational read port.
module dp_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lfsr.sv
// Fibonacci LFSR with seed load; an all-zero seed is replaced by 1 so the
// register can never lock up.
module lfsr #(
  parameter int unsigned         NUM_BITS = 20,
  parameter logic [NUM_BITS-1:0] TAPS     = NUM_BITS'(20'h90000)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seed_load,
  input  logic [NUM_BITS-1:0] seed,
  input  logic                advance,
  output logic [NUM_BITS-1:0] state
);

  logic [NUM_BITS-1:0] state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NUM_BITS'(1);
    end else if (seed_load) begin
      state_q <= (seed == '0) ? NUM_BITS'(1) : seed;
    end else if (advance) begin
      state_q <= {state_q[NUM_BITS-2:0], ^(state_q & TAPS)};
    end
  end

  assign state = state_q;

endmodule

// File: rtl/soma_sweep.sv
// Soma sweep engine: per timestep walks a neuron range, updates Vm and emits spikes.
// Optional per-neuron refractory counters are built when SOMA_REFRACTORY_EN is defined.
module soma_sweep
  import soma_pkg::*;
#(
  parameter int unsigned NNW = 12,
  parameter int unsigned VW  = 20,
  parameter int unsigned SDW = 20,
  parameter int unsigned RFW = 4
) (
  input  logic           clk_soma,
  input  logic           rst_n,
  input  logic           step_start,
  input  logic           step_clear,
  input  logic [1:0]     cfg_mode,
  input  logic [NNW-1:0] cfg_base,
  input  logic [NNW:0]   cfg_count,
  input  logic [VW-1:0]  cfg_vth,
  input  logic [VW-1:0]  cfg_leak,
  input  logic           cfg_reset_sub,
  input  logic [RFW-1:0] cfg_refr,
  input  logic [VW-1:0]  cfg_seed,
  input  logic           cfg_seed_load,
  input  logic           cfg_we,
  input  logic [NNW-1:0] cfg_waddr,
  input  logic [VW-1:0]  cfg_wdata,
  input  logic           cfg_re,
  input  logic [NNW-1:0] cfg_raddr,
  output logic [VW-1:0]  cfg_rdata,
  output logic [NNW-1:0] sd_raddr,
  input  logic [SDW-1:0] sd_rdata,
  output logic           spk_vld,
  input  logic           spk_rdy,
  output logic [NNW-1:0] spk_nid,
  output logic           busy,
  output logic           step_done
);

  localparam int unsigned XW = VW + 2;
  localparam logic [NNW:0] Full = {1'b1, {NNW{1'b0}}};

  soma_state_e    state_q, state_d;
  logic [NNW-1:0] addr_q;
  logic [NNW:0]   idx_q, count_q;
  logic [1:0]     mode_q;
  logic           clear_q;
  logic [VW-1:0]  vm_q, vm_new, ram_rdata, cfg_rdata_q, lfsr_state;
  logic           idle, fire, last, advance;

  logic signed [XW-1:0] vm_x, sd_x, vth_x, leak_x, sum_x;
  logic [VW-1:0]        sat_leak, sat_sub;

  assign idle    = (state_q == StIdle);
  assign last    = ((idx_q + 1'b1) == count_q);
  assign advance = ((state_q == StEv) && !fire) || ((state_q == StSpk) && spk_rdy);

  // Host port owns the RAM only while idle; the sweep owns it otherwise.
  dp_ram #(.AW(NNW), .DW(VW)) u_vm_ram (
    .clk   (clk_soma),
    .we    ((state_q == StEv) || (idle && cfg_we)),
    .waddr (idle ? cfg_waddr : addr_q),
    .wdata (idle ? cfg_wdata : vm_new),
    .raddr (idle ? cfg_raddr : addr_q),
    .rdata (ram_rdata)
  );

  lfsr #(.NUM_BITS(VW)) u_lfsr (
    .clk       (clk_soma),
    .rst_n     (rst_n),
    .seed_load (cfg_seed_load),
    .seed      (cfg_seed),
    .advance   ((state_q == StEv) && (mode_q == ModePoisson)),
    .state     (lfsr_state)
  );

`ifdef SOMA_REFRACTORY_EN
  logic [RFW-1:0] refr_q, refr_new, refr_rdata;

  dp_ram #(.AW(NNW), .DW(RFW)) u_refr_ram (
    .clk   (clk_soma),
    .we    (state_q == StEv),
    .waddr (addr_q),
    .wdata (refr_new),
    .raddr (addr_q),
    .rdata (refr_rdata)
  );

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      refr_q <= '0;
    end else if (state_q == StRd) begin
      refr_q <= refr_rdata;
    end
  end
`else
  logic unused_refr;
  assign unused_refr = ^cfg_refr;
`endif

  // Neuron arithmetic in VW+2 bits so vm + sd - leak cannot wrap before clamping.
  always_comb begin
    vm_x   = XW'(signed'(vm_q));
    sd_x   = XW'(signed'(sd_rdata));
    vth_x  = XW'(signed'(cfg_vth));
    leak_x = (mode_q == ModeIf) ? '0 : XW'(signed'(cfg_leak));
    sum_x  = vm_x + sd_x;
  end

  assign sat_leak = VW'(saturate(SatXW'(sum_x - leak_x), VW));
  assign sat_sub  = VW'(saturate(SatXW'(sum_x - vth_x), VW));

  always_comb begin
    fire   = 1'b0;
    vm_new = vm_q;
    case (mode_q)
      ModeLif, ModeIf: begin
        fire   = (sum_x >= vth_x);
        vm_new = fire ? (cfg_reset_sub ? sat_sub : '0) : sat_leak;
      end
      ModePoisson: fire = (lfsr_state < vm_q);
      default: ;
    endcase
`ifdef SOMA_REFRACTORY_EN
    refr_new = fire ? cfg_refr : refr_q;
    if ((refr_q != '0) && (mode_q != ModeOff)) begin
      fire     = 1'b0;
      vm_new   = vm_q;
      refr_new = refr_q - 1'b1;
    end
    if (clear_q) begin
      refr_new = '0;
    end
`endif
    if (clear_q) begin
      fire   = 1'b0;
      vm_new = '0;
    end
  end

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (step_start) state_d = (cfg_count == '0) ? StDone : StRd;
      StRd:   state_d = StEv;
      StEv:   state_d = fire ? StSpk : (last ? StDone : StRd);
      StSpk:  if (spk_rdy) state_d = last ? StDone : StRd;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      mode_q      <= ModeLif;
      clear_q     <= 1'b0;
      vm_q        <= '0;
      cfg_rdata_q <= '0;
    end else begin
      if (idle && step_start) begin
        addr_q  <= cfg_base;
        idx_q   <= '0;
        count_q <= (cfg_count > Full) ? Full : cfg_count;
        mode_q  <= cfg_mode;
        clear_q <= step_clear;
      end
      if (state_q == StRd) begin
        vm_q <= ram_rdata;
      end
      // Hold the address on the last neuron so sd_raddr stays in range.
      if (advance && !last) begin
        idx_q  <= idx_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
      if (idle && cfg_re) begin
        cfg_rdata_q <= ram_rdata;
      end
    end
  end

  always_comb begin
    busy      = !idle;
    step_done = (state_q == StDone);
    spk_vld   = (state_q == StSpk);
    spk_nid   = addr_q;
    sd_raddr  = addr_q;
    cfg_rdata = cfg_rdata_q;
  end

endmodule

// File: tb/tb_soma_sweep.sv
// Self-checking bench for soma_sweep: directed scenarios plus randomized sweeps
// checked against an arithmetic reference model of the neuron rules.
module tb_soma_sweep;

  localparam int NNW = 4;
  localparam int VW  = 20;
  localparam int SDW = 20;
  localparam int RFW = 4;
  localparam int N   = 16;

  logic           clk_soma = 1'b0;
  logic           rst_n;
  logic           step_start, step_clear, cfg_reset_sub, cfg_seed_load;
  logic [1:0]     cfg_mode;
  logic [NNW-1:0] cfg_base, cfg_waddr, cfg_raddr;
  logic [NNW:0]   cfg_count;
  logic [VW-1:0]  cfg_vth, cfg_leak, cfg_seed, cfg_wdata;
  logic [RFW-1:0] cfg_refr;
  logic           cfg_we, cfg_re;
  logic [VW-1:0]  cfg_rdata;
  logic [NNW-1:0] sd_raddr;
  logic [SDW-1:0] sd_rdata;
  logic           spk_vld, spk_rdy, busy, step_done;
  logic [NNW-1:0] spk_nid;

  soma_sweep #(.NNW(NNW), .VW(VW), .SDW(SDW), .RFW(RFW)) dut (
    .clk_soma      (clk_soma),
    .rst_n         (rst_n),
    .step_start    (step_start),
    .step_clear    (step_clear),
    .cfg_mode      (cfg_mode),
    .cfg_base      (cfg_base),
    .cfg_count     (cfg_count),
    .cfg_vth       (cfg_vth),
    .cfg_leak      (cfg_leak),
    .cfg_reset_sub (cfg_reset_sub),
    .cfg_refr      (cfg_refr),
    .cfg_seed      (cfg_seed),
    .cfg_seed_load (cfg_seed_load),
    .cfg_we        (cfg_we),
    .cfg_waddr     (cfg_waddr),
    .cfg_wdata     (cfg_wdata),
    .cfg_re        (cfg_re),
    .cfg_raddr     (cfg_raddr),
    .cfg_rdata     (cfg_rdata),
    .sd_raddr      (sd_raddr),
    .sd_rdata      (sd_rdata),
    .spk_vld       (spk_vld),
    .spk_rdy       (spk_rdy),
    .spk_nid       (spk_nid),
    .busy          (busy),
    .step_done     (step_done)
  );

  always #5 clk_soma = ~clk_soma;

  int checks = 0;
  int errors = 0;

  // Reference state
  int vm_m [N];
  int sd_m [N];
  int refr_m [N];
  int vth_i, leak_i, refr_i;
  bit rsub_i;
  int exp_q [$];
  logic [NNW-1:0] got_q [$];
  int hs_cnt;
  bit rdy_rand, rdy_fixed, cap_en;
  int addr_seq [$];

  // Dendrite block: one-cycle registered read.
  always @(posedge clk_soma) sd_rdata <= SDW'(sd_m[sd_raddr]);

  always @(posedge clk_soma) begin
    #1;
    spk_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  always @(negedge clk_soma) begin
    if (rst_n && spk_vld && spk_rdy) begin
      got_q.push_back(spk_nid);
      hs_cnt++;
    end
    if (cap_en && busy && (addr_seq.size() == 0 || addr_seq[$] != int'(sd_raddr)))
      addr_seq.push_back(int'(sd_raddr));
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] w20(int x);
    return {12'd0, x[19:0]};
  endfunction

  function automatic int sat(longint x);
    if (x > 524287) return 524287;
    if (x < -524288) return -524288;
    return int'(x);
  endfunction

  task automatic set_cfg(int vth, int leak, bit rsub, int refr);
    vth_i = vth; leak_i = leak; rsub_i = rsub; refr_i = refr;
    cfg_vth = VW'(vth); cfg_leak = VW'(leak); cfg_reset_sub = rsub; cfg_refr = RFW'(refr);
  endtask

  // Expected result of one sweep, straight from the neuron rules.
  task automatic model_sweep(int base, int count, logic [1:0] md, bit clr);
    int n;
    n = (count > N) ? N : count;
    for (int i = 0; i < n; i++) begin
      int a;
      longint sum;
      bit f;
      a = (base + i) % N;
      f = 1'b0;
      if (clr) begin
        vm_m[a] = 0;
        refr_m[a] = 0;
        continue;
      end
`ifdef SOMA_REFRACTORY_EN
      if (refr_m[a] > 0 && md != 2'b11) begin
        refr_m[a]--;
        continue;
      end
`endif
      case (md)
        2'b00, 2'b01: begin
          sum = longint'(vm_m[a]) + longint'(sd_m[a]);
          f = (sum >= longint'(vth_i));
          if (f) vm_m[a] = rsub_i ? sat(sum - longint'(vth_i)) : 0;
          else   vm_m[a] = sat(sum - ((md == 2'b01) ? 0 : longint'(leak_i)));
        end
        // Only full-scale (all-ones) or zero Vm is used in Poisson mode: from
        // seed 1 the generator is far from all-ones, so full-scale always fires.
        2'b10: f = (vm_m[a] == -1);
        default: ;
      endcase
      if (f) begin
        exp_q.push_back(a);
        refr_m[a] = refr_i;
      end
    end
  endtask

  task automatic wait_done(output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < 3000) begin
      @(negedge clk_soma);
      cycles++;
      if (step_done) seen = 1'b1;
    end
    check("step_done_seen", 32'(seen), 32'd1);
    @(posedge clk_soma); #1;
  endtask

  task automatic start(int base, int count, logic [1:0] md, bit clr);
    exp_q.delete(); got_q.delete(); hs_cnt = 0;
    model_sweep(base, count, md, clr);
    cfg_base = NNW'(base); cfg_count = (NNW+1)'(count); cfg_mode = md; step_clear = clr;
    step_start = 1'b1;
    @(posedge clk_soma); #1;
    step_start = 1'b0; step_clear = 1'b0;
  endtask

  task automatic compare_spikes(string tag);
    check({tag, "_nspk"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_nid"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic do_sweep(string tag, int base, int count, logic [1:0] md, bit clr);
    int cyc;
    start(base, count, md, clr);
    wait_done(cyc);
    compare_spikes(tag);
  endtask

  task automatic hwrite(int a, int v);
    cfg_we = 1'b1; cfg_waddr = NNW'(a); cfg_wdata = VW'(v);
    @(posedge clk_soma); #1;
    cfg_we = 1'b0;
    vm_m[a] = v;
  endtask

  task automatic hread(int a, output logic [VW-1:0] d);
    cfg_re = 1'b1; cfg_raddr = NNW'(a);
    @(posedge clk_soma); #1;
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic hcheck_all(string tag);
    logic [VW-1:0] d;
    for (int a = 0; a < N; a++) begin
      hread(a, d);
      check(tag, {12'd0, d}, w20(vm_m[a]));
    end
  endtask

  initial begin
    logic [VW-1:0] d;
    logic [NNW-1:0] nid0;
    int cyc;
    int lif_exp [4];
    bit seen;
    lif_exp = '{28, 56, 84, 14};
    rst_n = 1'b0; step_start = 1'b0; step_clear = 1'b0; cfg_mode = 2'b00;
    cfg_base = '0; cfg_count = '0; cfg_seed = '0; cfg_seed_load = 1'b0;
    cfg_we = 1'b0; cfg_waddr = '0; cfg_wdata = '0; cfg_re = 1'b0; cfg_raddr = '0;
    rdy_rand = 1'b0; rdy_fixed = 1'b1; cap_en = 1'b0;
    set_cfg(100, 0, 1'b1, 0);
    for (int a = 0; a < N; a++) begin sd_m[a] = 0; vm_m[a] = 0; refr_m[a] = 0; end
    repeat (3) @(posedge clk_soma);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_spk_vld", 32'(spk_vld), 32'd0);
    check("rst_step_done", 32'(step_done), 32'd0);
    check("rst_sd_raddr", 32'(sd_raddr), 32'd0);
    check("rst_spk_nid", 32'(spk_nid), 32'd0);
    check("rst_cfg_rdata", 32'(cfg_rdata), 32'd0);
    rst_n = 1'b1;
    @(posedge clk_soma); #1;

    // Clear sweep over random contents: all zero, no spikes.
    for (int a = 0; a < N; a++) hwrite(a, int'($urandom_range(0, 2000)) - 1000);
    for (int a = 0; a < N; a++) sd_m[a] = 5000;
    do_sweep("clear", 0, N, 2'b01, 1'b1);
    hcheck_all("clear_vm");
    for (int a = 0; a < N; a++) sd_m[a] = 0;

    // LIF accumulate on neuron 5.
    set_cfg(100, 2, 1'b1, 0);
    sd_m[5] = 30;
    for (int s = 0; s < 4; s++) begin
      do_sweep("lif", 5, 1, 2'b00, 1'b0);
      hread(5, d);
      check("lif_vm", {12'd0, d}, w20(lif_exp[s]));
      check("lif_spike", 32'(got_q.size()), (s == 3) ? 32'd1 : 32'd0);
    end
    hwrite(5, 84);
    set_cfg(100, 2, 1'b0, 0);
    do_sweep("lif_rz", 5, 1, 2'b00, 1'b0);
    hread(5, d);
    check("lif_reset_zero", {12'd0, d}, 32'd0);

    // Saturation at both rails.
    hwrite(3, 524280); sd_m[3] = 100;
    set_cfg(-10, 0, 1'b1, 0);
    do_sweep("sat_pos_fire", 3, 1, 2'b01, 1'b0);
    hread(3, d);
    check("sat_pos_fire_vm", {12'd0, d}, w20(524287));
    hwrite(3, 524280); sd_m[3] = 0;
    set_cfg(524287, -100, 1'b1, 0);
    do_sweep("sat_pos", 3, 1, 2'b00, 1'b0);
    hread(3, d);
    check("sat_pos_vm", {12'd0, d}, w20(524287));
    hwrite(3, -524280);
    set_cfg(100, 100, 1'b1, 0);
    do_sweep("sat_neg", 3, 1, 2'b00, 1'b0);
    hread(3, d);
    check("sat_neg_vm", {12'd0, d}, w20(-524288));

    // Range wrap and empty sweep.
    addr_seq.delete();
    cap_en = 1'b1;
    do_sweep("wrap", 14, 4, 2'b11, 1'b0);
    cap_en = 1'b0;
    check("wrap_len", 32'(addr_seq.size()), 32'd4);
    for (int i = 0; i < addr_seq.size() && i < 4; i++)
      check("wrap_addr", 32'(addr_seq[i]), 32'((14 + i) % N));
    start(0, 0, 2'b00, 1'b0);
    wait_done(cyc);
    check("count0_latency_le2", 32'(cyc <= 2), 32'd1);
    check("count0_nspk", 32'(got_q.size()), 32'd0);

    // Poisson: full-scale always fires, zero never fires; Vm untouched.
    set_cfg(100, 0, 1'b1, 0);
    cfg_seed = '0; cfg_seed_load = 1'b1;
    @(posedge clk_soma); #1;
    cfg_seed_load = 1'b0;
    for (int a = 0; a < 4; a++) hwrite(a, -1);
    do_sweep("poisson_full", 0, 4, 2'b10, 1'b0);
    for (int a = 4; a < 8; a++) hwrite(a, 0);
    do_sweep("poisson_zero", 4, 4, 2'b10, 1'b0);
    hcheck_all("poisson_vm");

    // Backpressure: three firing neurons, ready held low at first.
    for (int a = 8; a < 11; a++) begin hwrite(a, 0); sd_m[a] = 200; end
    set_cfg(100, 0, 1'b0, 0);
    rdy_fixed = 1'b0;
    start(8, 3, 2'b01, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk_soma);
      if (spk_vld) seen = 1'b1;
    end
    check("bp_vld_seen", 32'(seen), 32'd1);
    nid0 = spk_nid;
    check("bp_first_nid", 32'(nid0), 32'd8);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_soma);
      check("bp_hold_nid", 32'(spk_nid), 32'd8);
      check("bp_hold_vld", 32'(spk_vld), 32'd1);
    end
    rdy_fixed = 1'b1;
    wait_done(cyc);
    check("bp_handshakes", 32'(hs_cnt), 32'd3);
    compare_spikes("bp");
    hcheck_all("bp_vm");

    // Randomized sweeps against the model with random backpressure.
    rdy_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int md_sel;
      logic [1:0] md;
      md_sel = int'($urandom_range(0, 2));
      md = (md_sel == 2) ? 2'b11 : 2'(md_sel);
      set_cfg(int'($urandom_range(0, 2000)) - 500, int'($urandom_range(0, 60)) - 10,
              1'($urandom_range(0, 1)), 0);
      for (int a = 0; a < N; a++) begin
        if ($urandom_range(0, 7) == 0) sd_m[a] = ($urandom_range(0, 1) == 1) ? 524287 : -524288;
        else sd_m[a] = int'($urandom_range(0, 600)) - 300;
      end
      if (r == 4) hwrite(int'($urandom_range(0, 15)), 524000);
      do_sweep("rand", int'($urandom_range(0, 15)), int'($urandom_range(1, 17)), md, 1'b0);
      hcheck_all("rand_vm");
    end
    rdy_rand = 1'b0;
    rdy_fixed = 1'b1;

`ifdef SOMA_REFRACTORY_EN
    // Refractory: fires on steps 1 and 4, silent on 2 and 3.
    hwrite(0, 0); sd_m[0] = 1000;
    set_cfg(100, 0, 1'b0, 2);
    for (int s = 0; s < 4; s++) begin
      do_sweep("refr", 0, 1, 2'b01, 1'b0);
      check("refr_spike", 32'(got_q.size()), (s == 0 || s == 3) ? 32'd1 : 32'd0);
    end
    set_cfg(100, 0, 1'b0, 0);
`endif

    // Asynchronous reset while a spike is pending.
    hwrite(2, 0); sd_m[2] = 1000;
    set_cfg(100, 0, 1'b0, 0);
    rdy_fixed = 1'b0;
    start(2, 1, 2'b01, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk_soma);
      if (spk_vld) seen = 1'b1;
    end
    check("rst_mid_vld_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_spk_vld", 32'(spk_vld), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
